// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and round-function helpers.
// Byte i of a 128-bit block lives at [8i +: 8], bit 0 is the MSB.
package aes_pkg;

  localparam int NB = 4;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox_byte(
    input logic [7:0] b
  );
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [0:31] mix_column(
    input logic [0:31] c
  );
    logic [7:0] a0, a1, a2, a3;
    a0 = c[0:7];
    a1 = c[8:15];
    a2 = c[16:23];
    a3 = c[24:31];
    return {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  endfunction

  // Row r of column c takes the byte from column c+r.
  function automatic logic [0:127] shift_rows(
    input logic [0:127] s
  );
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] =
          s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single AES S-box byte substitution, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] subst
);

  assign subst = sbox_byte(data);

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core, one round per clock, fed by a
// precomputed key schedule; AES-128/192/256 through NK.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = NK + 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:127]             plaintext,
  input  logic [0:128*(NR+1)-1]    key_schedule,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:127]             ciphertext,
  output logic                     busy
);

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state;
  logic [3:0]   rnd;
  logic [0:127] st;
  logic [0:127] sb;
  logic [0:127] sr;
  logic [0:127] mc;
  logic [0:127] rk;
  logic [0:127] nxt;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (
      .data  (st[8*i +: 8]),
      .subst (sb[8*i +: 8])
    );
  end

  always_comb begin
    sr = shift_rows(sb);
    mc = '0;
    for (int c = 0; c < NB; c++) begin
      mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
    end
  end

  assign rk  = key_schedule[{rnd, 7'd0} +: 128];
  // The final round skips MixColumns.
  assign nxt = (rnd == LAST) ? (sr ^ rk) : (mc ^ rk);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rnd        <= '0;
      st         <= '0;
      ciphertext <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          rnd <= '0;
          if (in_valid && in_ready) begin
            st       <= plaintext ^ key_schedule[0:127];
            rnd      <= 4'd1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ROUND;
          end
        end
        ROUND: begin
          st <= nxt;
          if (rnd == LAST) begin
            ciphertext <= nxt;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed FIPS-197 vectors against AES-128/192/256 instances,
// with backpressure, back-to-back and mid-block reset cases.
module tb_aes_cipher_iter;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:255] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] KEY_C =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   in_valid = '0;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready = '1;
  logic [2:0]   busy;
  logic [0:127] pt [3];
  logic [0:127] ct [3];
  logic [0:1919] ks [3];

  int total = 0;
  int bad = 0;
  logic [7:0] sb [256];

  always #5 clk = ~clk;

  aes_cipher_iter #(.NK(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .plaintext(pt[0]), .key_schedule(ks[0][0:1407]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .ciphertext(ct[0]), .busy(busy[0])
  );

  aes_cipher_iter #(.NK(6)) dut6 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .plaintext(pt[1]), .key_schedule(ks[1][0:1663]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .ciphertext(ct[1]), .busy(busy[1])
  );

  aes_cipher_iter #(.NK(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .plaintext(pt[2]), .key_schedule(ks[2][0:1919]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .ciphertext(ct[2]), .busy(busy[2])
  );

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box derived from the GF(2^8) inverse plus affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input int idx, input logic [0:255] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    int nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    ks[idx] = '0;
    for (int i = 0; i < nw; i++) ks[idx][32*i +: 32] = w[i];
  endtask

  task automatic run_block(input int idx, input string tag,
                           input logic [127:0] p, input logic [127:0] e,
                           input int lat);
    int n;
    pt[idx] = p;
    in_valid[idx] = 1'b1;
    n = 0;
    while (!in_ready[idx] && n < 50) begin
      step();
      n++;
    end
    step();
    in_valid[idx] = 1'b0;
    pt[idx] = '1;
    n = 0;
    while (!out_valid[idx] && n < 40) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 128'(n), 128'(lat));
    check({tag, "_ct"}, ct[idx], e);
  endtask

  initial begin
    int seen;
    int tm [2];
    logic [127:0] hold;
    logic rose;
    for (int i = 0; i < 3; i++) pt[i] = '0;
    build_sbox();
    expand(0, KEY_B, 4);
    repeat (2) step();
    reset = 1'b0;
    check("rst_in_ready", 128'(in_ready[0]), 128'd1);
    check("rst_out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_busy", 128'(busy[0]), 128'd0);
    check("rst_ct", ct[0], 128'd0);

    run_block(0, "appb", PT_B, CT_B, 10);
    step();
    check("appb_ready", 128'(in_ready[0]), 128'd1);

    expand(0, KEY_C, 4);
    expand(1, KEY_C, 6);
    expand(2, KEY_C, 8);
    run_block(0, "c1", PT_C, CT_C1, 10);
    step();
    check("c1_ready", 128'(in_ready[0]), 128'd1);
    run_block(1, "c2", PT_C, CT_C2, 12);
    step();
    check("c2_ready", 128'(in_ready[1]), 128'd1);
    run_block(2, "c3", PT_C, CT_C3, 14);
    step();
    check("c3_ready", 128'(in_ready[2]), 128'd1);

    out_ready[0] = 1'b0;
    run_block(0, "bp", PT_C, CT_C1, 10);
    hold = ct[0];
    for (int k = 0; k < 5; k++) begin
      in_valid[0] = (k % 2 == 0);
      pt[0] = {$urandom, $urandom, $urandom, $urandom};
      step();
      check("bp_hold_ct", ct[0], hold);
      check("bp_hold_ov", 128'(out_valid[0]), 128'd1);
      check("bp_hold_ir", 128'(in_ready[0]), 128'd0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    step();
    check("bp_hs_ov", 128'(out_valid[0]), 128'd0);
    check("bp_hs_ir", 128'(in_ready[0]), 128'd1);
    check("bp_hs_busy", 128'(busy[0]), 128'd0);

    pt[0] = PT_C;
    in_valid[0] = 1'b1;
    seen = 0;
    tm[0] = 0;
    tm[1] = 0;
    for (int cyc = 1; cyc <= 60 && seen < 2; cyc++) begin
      step();
      if (out_valid[0]) begin
        check("b2b_ct", ct[0], CT_C1);
        tm[seen] = cyc;
        seen++;
      end
    end
    in_valid[0] = 1'b0;
    check("b2b_count", 128'(seen), 128'd2);
    check("b2b_gap", 128'(tm[1] - tm[0]), 128'd12);

    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_ir", 128'(in_ready[0]), 128'd1);
    check("mid_rst_busy", 128'(busy[0]), 128'd0);
    check("mid_rst_ov", 128'(out_valid[0]), 128'd0);
    rose = 1'b0;
    repeat (20) begin
      step();
      if (out_valid[0]) rose = 1'b1;
    end
    check("mid_rst_no_out", 128'(rose), 128'd0);
    run_block(0, "post_rst", PT_C, CT_C1, 10);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
